// File: rtl/recepcao_medida_serial_pkg.sv
// rtl/recepcao_medida_serial_pkg.sv - shared encodings and defaults for the distance telemetry receiver
package recepcao_medida_serial_pkg;

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        INICIO = 2'd1,
        DADOS  = 2'd2,
        PARADA = 2'd3
    } rx_estado_t;

    typedef enum logic [1:0] {
        ESPERA_D0  = 2'd0,
        ESPERA_D1  = 2'd1,
        ESPERA_D2  = 2'd2,
        ESPERA_FIM = 2'd3
    } parser_estado_t;

    localparam int         CLKS_PER_BIT_PADRAO = 5208;
    localparam logic [7:0] CHAR_OFFSET_PADRAO  = 8'h30;
    localparam logic [7:0] CHAR_FIM_PADRAO     = 8'h23;

endpackage

// File: rtl/recepcao_medida_serial_rx.sv
// rtl/recepcao_medida_serial_rx.sv - 8N1 UART byte receiver with start-bit validation and stop-bit check
module rx_serial_8N1
    import recepcao_medida_serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_PADRAO
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       RX,
    output logic [7:0] dados,
    output logic       byte_valido,
    output logic       erro_quadro,
    output logic [1:0] estado
);

    localparam int             CW     = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  ULTIMO = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  MEIO   = CW'(CLKS_PER_BIT / 2 - 1);

    rx_estado_t    atual, prox;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    desloc;
    logic          rx_ant;
    logic          fim_meio, fim_bit;

    assign fim_meio = (cnt == MEIO);
    assign fim_bit  = (cnt == ULTIMO);
    assign estado   = atual;

    always_comb begin
        prox = atual;
        case (atual)
            OCIOSO: if (rx_ant && !RX) prox = INICIO;
            INICIO: if (fim_meio) prox = RX ? OCIOSO : DADOS;
            DADOS:  if (fim_bit && bit_cnt == 3'd7) prox = PARADA;
            PARADA: if (fim_bit) prox = OCIOSO;
            default: prox = OCIOSO;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            atual       <= OCIOSO;
            cnt         <= '0;
            bit_cnt     <= '0;
            desloc      <= '0;
            rx_ant      <= 1'b1;
            dados       <= '0;
            byte_valido <= 1'b0;
            erro_quadro <= 1'b0;
        end else begin
            atual       <= prox;
            rx_ant      <= RX;
            byte_valido <= 1'b0;
            erro_quadro <= 1'b0;
            // The half-bit wait in INICIO re-aligns every later sample to mid-bit.
            if (prox != atual || atual == OCIOSO || fim_bit)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
            case (atual)
                OCIOSO: bit_cnt <= '0;
                DADOS: if (fim_bit) begin
                    desloc  <= {RX, desloc[7:1]};
                    bit_cnt <= bit_cnt + 1'b1;
                end
                PARADA: if (fim_bit) begin
                    if (RX) begin
                        dados       <= desloc;
                        byte_valido <= 1'b1;
                    end else begin
                        erro_quadro <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/recepcao_medida_serial.sv
// rtl/recepcao_medida_serial.sv - deserialises "D0 D1 D2 #" ASCII frames into a 12-bit distance
module recepcao_medida_serial
    import recepcao_medida_serial_pkg::*;
#(
    parameter int         CLKS_PER_BIT = CLKS_PER_BIT_PADRAO,
    parameter logic [7:0] CHAR_OFFSET  = CHAR_OFFSET_PADRAO,
    parameter logic [7:0] CHAR_FIM     = CHAR_FIM_PADRAO
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        RX,
    output logic [11:0] distancia,
    output logic        medida_pronta,
    output logic        erro_quadro,
    output logic        erro_caracter,
    output logic [3:0]  db_estado
);

    logic           rx_meta, rx_sinc;
    logic [7:0]     dados;
    logic           byte_valido;
    logic [1:0]     estado_rx;
    parser_estado_t estado, prox;
    logic [3:0]     n0, n1, n2;
    logic [7:0]     dif;
    logic           eh_digito, grava, concluir, erro_car;

    always_ff @(posedge clock) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_sinc <= 1'b1;
        end else begin
            rx_meta <= RX;
            rx_sinc <= rx_meta;
        end
    end

    rx_serial_8N1 #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clock      (clock),
        .reset      (reset),
        .RX         (rx_sinc),
        .dados      (dados),
        .byte_valido(byte_valido),
        .erro_quadro(erro_quadro),
        .estado     (estado_rx)
    );

    assign dif       = dados - CHAR_OFFSET;
    assign eh_digito = (dados >= CHAR_OFFSET) && (dif[7:4] == 4'd0);
    assign db_estado = {estado_rx, estado};

    always_comb begin
        prox     = estado;
        grava    = 1'b0;
        concluir = 1'b0;
        erro_car = 1'b0;
        if (erro_quadro) begin
            prox = ESPERA_D0;
        end else if (byte_valido) begin
            case (estado)
                ESPERA_FIM: begin
                    if (dados == CHAR_FIM) concluir = 1'b1;
                    else                   erro_car = 1'b1;
                    prox = ESPERA_D0;
                end
                default: begin
                    // A stray '#' in a digit slot also lands here, so the next byte is D0.
                    if (eh_digito) begin
                        grava = 1'b1;
                        case (estado)
                            ESPERA_D0: prox = ESPERA_D1;
                            ESPERA_D1: prox = ESPERA_D2;
                            default:   prox = ESPERA_FIM;
                        endcase
                    end else begin
                        erro_car = 1'b1;
                        prox     = ESPERA_D0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            estado        <= ESPERA_D0;
            n0            <= '0;
            n1            <= '0;
            n2            <= '0;
            distancia     <= '0;
            medida_pronta <= 1'b0;
            erro_caracter <= 1'b0;
        end else begin
            estado        <= prox;
            medida_pronta <= concluir;
            erro_caracter <= erro_car;
            if (grava) begin
                case (estado)
                    ESPERA_D0: n0 <= dif[3:0];
                    ESPERA_D1: n1 <= dif[3:0];
                    default:   n2 <= dif[3:0];
                endcase
            end
            if (concluir) distancia <= {n0, n1, n2};
        end
    end

endmodule

// File: tb/tb_recepcao_medida_serial.sv
// tb/tb_recepcao_medida_serial.sv - scoreboard bench for the distance telemetry receiver
module tb_recepcao_medida_serial;

    localparam int CPB = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        RX    = 1'b1;
    logic [11:0] distancia;
    logic        medida_pronta, erro_quadro, erro_caracter;
    logic [3:0]  db_estado;

    int n_checks = 0;
    int n_pass   = 0;

    logic [11:0] exp_q[$];
    logic [11:0] obs_q[$];
    int cyc = 0, last_bv = -100;
    int n_pronta = 0, n_eq = 0, n_ec = 0, n_bv = 0;
    int lat_err = 0, longo = 0, excl = 0;
    logic pronta_ant = 1'b0;

    recepcao_medida_serial #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .RX           (RX),
        .distancia    (distancia),
        .medida_pronta(medida_pronta),
        .erro_quadro  (erro_quadro),
        .erro_caracter(erro_caracter),
        .db_estado    (db_estado)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (dut.u_rx.byte_valido) begin
            last_bv = cyc;
            n_bv++;
        end
        if (medida_pronta) begin
            obs_q.push_back(distancia);
            n_pronta++;
            if (cyc - last_bv != 1) lat_err++;
            if (pronta_ant) longo++;
        end
        pronta_ant = medida_pronta;
        if (erro_quadro) n_eq++;
        if (erro_caracter) n_ec++;
        if (int'(medida_pronta) + int'(erro_quadro) + int'(erro_caracter) > 1) excl++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        RX = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            tick(CPB);
        end
        RX = stop;
        tick(CPB);
        RX = 1'b1;
        if (!stop) tick(CPB);
    endtask

    task automatic send_frame(input logic [7:0] b0, b1, b2, b3);
        send_byte(b0, 1'b1);
        send_byte(b1, 1'b1);
        send_byte(b2, 1'b1);
        send_byte(b3, 1'b1);
        tick(8);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick(3);
        n_checks++;
        if (distancia !== 12'h000) $display("FAIL reset_distancia got=%h want=000", distancia);
        else n_pass++;
        n_checks++;
        if ({medida_pronta, erro_quadro, erro_caracter} !== 3'b000)
            $display("FAIL reset_pulses got=%b want=000", {medida_pronta, erro_quadro, erro_caracter});
        else n_pass++;
        n_checks++;
        if (db_estado !== 4'h0) $display("FAIL reset_estado got=%h want=0", db_estado);
        else n_pass++;
        reset = 1'b1;
        tick(2);
    endtask

    task automatic test_frame_basic();
        int ec0 = n_ec, eq0 = n_eq;
        exp_q.push_back(12'h1A5);
        send_frame(8'h31, 8'h3A, 8'h35, 8'h23);
        n_checks++;
        if (obs_q.size() !== exp_q.size()) $display("FAIL basic_count got=%0d want=%0d", obs_q.size(), exp_q.size());
        else n_pass++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [11:0] e = exp_q.pop_front();
            logic [11:0] o = obs_q.pop_front();
            n_checks++;
            if (o !== e) $display("FAIL basic_distancia got=%h want=%h", o, e);
            else n_pass++;
        end
        exp_q.delete(); obs_q.delete();
        n_checks++;
        if (n_ec - ec0 + n_eq - eq0 != 0) $display("FAIL basic_no_errors got=%0d want=0", n_ec - ec0 + n_eq - eq0);
        else n_pass++;
        n_checks++;
        if (longo !== 0) $display("FAIL basic_pulse_width got=%0d want=0", longo);
        else n_pass++;
        n_checks++;
        if (lat_err !== 0) $display("FAIL basic_latency got=%0d want=0", lat_err);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int p0 = n_pronta;
        exp_q.push_back(12'hFFF);
        send_frame(8'h3F, 8'h3F, 8'h3F, 8'h23);
        exp_q.push_back(12'h000);
        send_frame(8'h30, 8'h30, 8'h30, 8'h23);
        n_checks++;
        if (n_pronta - p0 != 2) $display("FAIL b2b_pulses got=%0d want=2", n_pronta - p0);
        else n_pass++;
        n_checks++;
        if (obs_q.size() !== exp_q.size()) $display("FAIL b2b_count got=%0d want=%0d", obs_q.size(), exp_q.size());
        else n_pass++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [11:0] e = exp_q.pop_front();
            logic [11:0] o = obs_q.pop_front();
            n_checks++;
            if (o !== e) $display("FAIL b2b_distancia got=%h want=%h", o, e);
            else n_pass++;
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_char_error();
        int ec0 = n_ec, p0 = n_pronta;
        send_byte(8'h31, 1'b1);
        send_byte(8'h23, 1'b1);
        tick(8);
        n_checks++;
        if (n_ec - ec0 != 1) $display("FAIL char_err_pulse got=%0d want=1", n_ec - ec0);
        else n_pass++;
        n_checks++;
        if (n_pronta - p0 != 0 || distancia !== 12'h000)
            $display("FAIL char_err_unchanged got=%h/%0d want=000/0", distancia, n_pronta - p0);
        else n_pass++;
        exp_q.push_back(12'h234);
        send_frame(8'h32, 8'h33, 8'h34, 8'h23);
        n_checks++;
        if (obs_q.size() !== exp_q.size()) $display("FAIL char_err_count got=%0d want=%0d", obs_q.size(), exp_q.size());
        else n_pass++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [11:0] e = exp_q.pop_front();
            logic [11:0] o = obs_q.pop_front();
            n_checks++;
            if (o !== e) $display("FAIL char_err_distancia got=%h want=%h", o, e);
            else n_pass++;
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_frame_error();
        int eq0 = n_eq, bv0 = n_bv, ec0 = n_ec;
        send_byte(8'h31, 1'b0);
        tick(8);
        n_checks++;
        if (n_eq - eq0 != 1) $display("FAIL frame_err_pulse got=%0d want=1", n_eq - eq0);
        else n_pass++;
        n_checks++;
        if (n_bv - bv0 != 0 || n_ec - ec0 != 0)
            $display("FAIL frame_err_no_byte got=%0d/%0d want=0/0", n_bv - bv0, n_ec - ec0);
        else n_pass++;
        n_checks++;
        if (db_estado !== 4'h0) $display("FAIL frame_err_estado got=%h want=0", db_estado);
        else n_pass++;
        exp_q.push_back(12'h567);
        send_frame(8'h35, 8'h36, 8'h37, 8'h23);
        n_checks++;
        if (obs_q.size() !== exp_q.size()) $display("FAIL frame_err_count got=%0d want=%0d", obs_q.size(), exp_q.size());
        else n_pass++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [11:0] e = exp_q.pop_front();
            logic [11:0] o = obs_q.pop_front();
            n_checks++;
            if (o !== e) $display("FAIL frame_err_distancia got=%h want=%h", o, e);
            else n_pass++;
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_glitch();
        int bv0 = n_bv, pulses0 = n_pronta + n_eq + n_ec;
        RX = 1'b0;
        tick(1);
        RX = 1'b1;
        tick(12);
        n_checks++;
        if (n_bv - bv0 != 0) $display("FAIL glitch_no_byte got=%0d want=0", n_bv - bv0);
        else n_pass++;
        n_checks++;
        if (n_pronta + n_eq + n_ec - pulses0 != 0)
            $display("FAIL glitch_no_pulses got=%0d want=0", n_pronta + n_eq + n_ec - pulses0);
        else n_pass++;
        n_checks++;
        if (db_estado[3:2] !== 2'd0) $display("FAIL glitch_rx_ocioso got=%0d want=0", db_estado[3:2]);
        else n_pass++;
        n_checks++;
        if (distancia !== 12'h567) $display("FAIL glitch_hold got=%h want=567", distancia);
        else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        send_byte(8'h31, 1'b1);
        send_byte(8'h32, 1'b1);
        reset = 1'b0;
        tick(2);
        n_checks++;
        if (distancia !== 12'h000) $display("FAIL midreset_distancia got=%h want=000", distancia);
        else n_pass++;
        reset = 1'b1;
        tick(2);
        n_checks++;
        if (db_estado !== 4'h0) $display("FAIL midreset_estado got=%h want=0", db_estado);
        else n_pass++;
        exp_q.push_back(12'h345);
        send_frame(8'h33, 8'h34, 8'h35, 8'h23);
        n_checks++;
        if (obs_q.size() !== exp_q.size()) $display("FAIL midreset_count got=%0d want=%0d", obs_q.size(), exp_q.size());
        else n_pass++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [11:0] e = exp_q.pop_front();
            logic [11:0] o = obs_q.pop_front();
            n_checks++;
            if (o !== e) $display("FAIL midreset_distancia_final got=%h want=%h", o, e);
            else n_pass++;
        end
        exp_q.delete(); obs_q.delete();
    endtask

    initial begin
        tick(1);
        test_reset();
        test_frame_basic();
        test_back_to_back();
        test_char_error();
        test_frame_error();
        test_glitch();
        test_reset_mid_frame();
        n_checks++;
        if (excl !== 0) $display("FAIL pulse_exclusive got=%0d want=0", excl);
        else n_pass++;
        n_checks++;
        if (lat_err !== 0 || longo !== 0) $display("FAIL pronta_timing got=%0d/%0d want=0/0", lat_err, longo);
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
